// File: rtl/rv32i_alu_regfile_if.sv
// Bus between the CPU datapath control and the RV32I register file / ALU core.
// Master drives indices, write data, ALU operands and op select; slave returns read data, result and flags.
interface rv32i_alu_regfile_if;
   localparam int unsigned XLEN  = 32;
   localparam int unsigned IDX_W = 5;
   localparam int unsigned SEL_W = 4;

   logic             we;
   logic [IDX_W-1:0] rd;
   logic [XLEN-1:0]  indata;
   logic [IDX_W-1:0] rs1;
   logic [IDX_W-1:0] rs2;
   logic [XLEN-1:0]  outdata_rs1;
   logic [XLEN-1:0]  outdata_rs2;

   logic [XLEN-1:0]  a;
   logic [XLEN-1:0]  b;
   logic [SEL_W-1:0] selectop;
   logic [XLEN-1:0]  out;
   logic             neq;
   logic             eq;
   logic             lt;
   logic             ge;
   logic             ltu;
   logic             geu;
   logic             zerof;

   modport master (
      output we, rd, indata, rs1, rs2, a, b, selectop,
      input  outdata_rs1, outdata_rs2, out, neq, eq, lt, ge, ltu, geu, zerof
   );

   modport slave (
      input  we, rd, indata, rs1, rs2, a, b, selectop,
      output outdata_rs1, outdata_rs2, out, neq, eq, lt, ge, ltu, geu, zerof
   );
endinterface

// File: rtl/rv32i_alu_regfile.sv
// RV32I 32x32 register file (x0 hardwired to zero) plus combinational ALU with compare flags.
// Optional write-first read forwarding is enabled by defining RV32I_REGFILE_BYPASS_EN.
module rv32i_alu_regfile (
   input  logic                 sys_clk,
   input  logic                 sys_reset,
   rv32i_alu_regfile_if.slave   bus
);
   localparam int unsigned XLEN    = 32;
   localparam int unsigned NREGS   = 32;
   localparam int unsigned IDX_W   = 5;
   localparam int unsigned SHAMT_W = 5;

   logic [XLEN-1:0] regs_q [NREGS];
   logic [XLEN-1:0] regs_d [NREGS];
   logic            wr_en_c;

   assign wr_en_c = bus.we && (bus.rd != IDX_W'(0));

   // Next-state of the register array; x0 is never updated.
   always_comb begin
      regs_d = regs_q;
      if (wr_en_c) begin
         regs_d[bus.rd] = bus.indata;
      end
   end

   // Async reset clears the whole file; held reset also blocks writes.
   always_ff @(posedge sys_clk or negedge sys_reset) begin
      if (!sys_reset) begin
         for (int i = 0; i < int'(NREGS); i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         regs_q <= regs_d;
      end
   end

   // Asynchronous read ports.
   always_comb begin
      bus.outdata_rs1 = '0;
      bus.outdata_rs2 = '0;
      if (bus.rs1 != IDX_W'(0)) begin
         bus.outdata_rs1 = regs_q[bus.rs1];
      end
      if (bus.rs2 != IDX_W'(0)) begin
         bus.outdata_rs2 = regs_q[bus.rs2];
      end
`ifdef RV32I_REGFILE_BYPASS_EN
      if (wr_en_c && (bus.rd == bus.rs1)) begin
         bus.outdata_rs1 = bus.indata;
      end
      if (wr_en_c && (bus.rd == bus.rs2)) begin
         bus.outdata_rs2 = bus.indata;
      end
`endif
   end

   logic [SHAMT_W-1:0] shamt_c;
   logic               slt_c;
   logic               sltu_c;

   assign shamt_c = bus.b[SHAMT_W-1:0];
   assign slt_c   = $signed(bus.a) < $signed(bus.b);
   assign sltu_c  = bus.a < bus.b;

   // ALU: funct7[5] only distinguishes ADD/SUB and SRL/SRA.
   always_comb begin
      bus.out = '0;
      unique case (bus.selectop[2:0])
         3'b000:  bus.out = bus.selectop[3] ? (bus.a - bus.b) : (bus.a + bus.b);
         3'b001:  bus.out = bus.a << shamt_c;
         3'b010:  bus.out = XLEN'(slt_c);
         3'b011:  bus.out = XLEN'(sltu_c);
         3'b100:  bus.out = bus.a ^ bus.b;
         3'b101:  bus.out = bus.selectop[3] ? XLEN'($signed(bus.a) >>> shamt_c)
                                            : (bus.a >> shamt_c);
         3'b110:  bus.out = bus.a | bus.b;
         3'b111:  bus.out = bus.a & bus.b;
         default: bus.out = '0;
      endcase
   end

   // Branch flags always compare a against b.
   always_comb begin
      bus.eq    = (bus.a == bus.b);
      bus.neq   = ~bus.eq;
      bus.lt    = slt_c;
      bus.ge    = ~slt_c;
      bus.ltu   = sltu_c;
      bus.geu   = ~sltu_c;
      bus.zerof = (bus.out == '0);
   end
endmodule

// File: tb/tb_rv32i_alu_regfile.sv
// Randomized self-checking bench for rv32i_alu_regfile against an arithmetic reference model.
module tb_rv32i_alu_regfile;
   logic sys_clk;
   logic sys_reset;
   int   n_vec;
   int   n_err;
   logic [31:0] mdl [32];

   rv32i_alu_regfile_if bus ();

   rv32i_alu_regfile dut (
      .sys_clk   (sys_clk),
      .sys_reset (sys_reset),
      .bus       (bus.slave)
   );

   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] ref_alu(input logic [31:0] x, input logic [31:0] y,
                                           input logic [3:0] s);
      int unsigned sh;
      sh = y % 32;
      case (s[2:0])
         3'd0: return s[3] ? x - y : x + y;
         3'd1: return 32'(64'(x) * (64'd1 << sh));
         3'd2: return (int'(x) < int'(y)) ? 32'd1 : 32'd0;
         3'd3: return (x < y) ? 32'd1 : 32'd0;
         3'd4: return x ^ y;
         3'd5: begin
            if (s[3] && x[31]) return ~((~x) / (32'd1 << sh));
            return x / (32'd1 << sh);
         end
         3'd6: return x | y;
         default: return x & y;
      endcase
   endfunction

   function automatic logic [6:0] ref_flags(input logic [31:0] x, input logic [31:0] y,
                                            input logic [3:0] s);
      bit slt;
      bit sltu;
      slt  = int'(x) < int'(y);
      sltu = x < y;
      return {x != y, x == y, slt, !slt, sltu, !sltu, ref_alu(x, y, s) == 32'd0};
   endfunction

   // Expected read data for a port, including same-cycle forwarding when built with it.
   function automatic logic [31:0] ref_read(input logic [4:0] idx);
      if (idx == 5'd0) return 32'd0;
`ifdef RV32I_REGFILE_BYPASS_EN
      if (bus.we && bus.rd == idx) return bus.indata;
`endif
      return mdl[idx];
   endfunction

   // Advance one clock, mirroring the architectural write into the model.
   task automatic tick();
      bit do_wr;
      logic [4:0]  wr_idx;
      logic [31:0] wr_val;
      do_wr  = sys_reset && bus.we && (bus.rd != 5'd0);
      wr_idx = bus.rd;
      wr_val = bus.indata;
      @(posedge sys_clk);
      if (do_wr) mdl[wr_idx] = wr_val;
      #1;
   endtask

   task automatic check_reads(input string tag);
      check({tag, "_rs1"}, bus.outdata_rs1, ref_read(bus.rs1));
      check({tag, "_rs2"}, bus.outdata_rs2, ref_read(bus.rs2));
   endtask

   task automatic check_alu(input string tag, input logic [31:0] x, input logic [31:0] y,
                            input logic [3:0] s, input logic [31:0] exp_out);
      bus.a = x; bus.b = y; bus.selectop = s;
      #1;
      check({tag, "_out"}, bus.out, exp_out);
      check({tag, "_ref"}, bus.out, ref_alu(x, y, s));
      check({tag, "_flags"},
            32'({bus.neq, bus.eq, bus.lt, bus.ge, bus.ltu, bus.geu, bus.zerof}),
            32'(ref_flags(x, y, s)));
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      for (int i = 0; i < 32; i++) mdl[i] = 32'd0;
      sys_reset = 1'b0;
      bus.we = 1'b0; bus.rd = '0; bus.indata = '0; bus.rs1 = '0; bus.rs2 = '0;
      bus.a = '0; bus.b = '0; bus.selectop = '0;
      #12;
      sys_reset = 1'b1;
      #1;
      bus.rs1 = 5'd5; bus.rs2 = 5'd31;
      #1;
      check("rst_state_rs1", bus.outdata_rs1, 32'd0);
      check("rst_state_rs2", bus.outdata_rs2, 32'd0);

      // Reset mid-cycle clears immediately; writes under reset are dropped.
      bus.we = 1'b1; bus.rd = 5'd5; bus.indata = 32'hDEADBEEF;
      tick();
      bus.we = 1'b0;
      #1;
      check("wr_x5", bus.outdata_rs1, 32'hDEADBEEF);
      #2;
      sys_reset = 1'b0;
      for (int i = 0; i < 32; i++) mdl[i] = 32'd0;
      #1;
      check("async_rst", bus.outdata_rs1, 32'd0);
      bus.we = 1'b1; bus.indata = 32'h0BADF00D;
      tick();
      bus.we = 1'b0;
      check("wr_in_rst", bus.outdata_rs1, 32'd0);
      @(negedge sys_clk);
      sys_reset = 1'b1;

      // x0 protection.
      bus.we = 1'b1; bus.rd = 5'd0; bus.indata = 32'h12345678; bus.rs1 = 5'd0;
      #1;
      check("x0_pre", bus.outdata_rs1, 32'd0);
      tick();
      check("x0_post", bus.outdata_rs1, 32'd0);

      // x31 visible after the edge.
      bus.rd = 5'd31; bus.indata = 32'hFFFFFFFF; bus.rs2 = 5'd31;
      #1;
`ifdef RV32I_REGFILE_BYPASS_EN
      check("x31_pre", bus.outdata_rs2, 32'hFFFFFFFF);
`else
      check("x31_pre", bus.outdata_rs2, 32'd0);
`endif
      tick();
      bus.we = 1'b0;
      #1;
      check("x31_post", bus.outdata_rs2, 32'hFFFFFFFF);

      // Same-index read during write.
      bus.we = 1'b1; bus.rd = 5'd7; bus.indata = 32'h11111111; bus.rs1 = 5'd7; bus.rs2 = 5'd7;
      tick();
      bus.indata = 32'hA5A5A5A5;
      #1;
`ifdef RV32I_REGFILE_BYPASS_EN
      check("byp_rs1", bus.outdata_rs1, 32'hA5A5A5A5);
`else
      check("byp_rs1", bus.outdata_rs1, 32'h11111111);
`endif
      check_reads("byp_model");
      tick();
      bus.we = 1'b0;
      #1;
      check("byp_post_rs1", bus.outdata_rs1, 32'hA5A5A5A5);
      check("byp_post_rs2", bus.outdata_rs2, 32'hA5A5A5A5);

      // Directed ALU corners.
      check_alu("add_ovf", 32'h7FFFFFFF, 32'd1, 4'b0000, 32'h80000000);
      check_alu("sub_zero", 32'd5, 32'd5, 4'b1000, 32'd0);
      check("sub_eq", 32'(bus.eq), 32'd1);
      check("sub_neq", 32'(bus.neq), 32'd0);
      check("sub_zf", 32'(bus.zerof), 32'd1);
      check_alu("sll", 32'h80000000, 32'h21, 4'b0001, 32'h00000000);
      check_alu("srl", 32'h80000000, 32'h21, 4'b0101, 32'h40000000);
      check_alu("sra", 32'h80000000, 32'h21, 4'b1101, 32'hC0000000);
      check_alu("slt", 32'hFFFFFFFF, 32'd1, 4'b0010, 32'd1);
      check("cmp_lt", 32'(bus.lt), 32'd1);
      check("cmp_ltu", 32'(bus.ltu), 32'd0);
      check_alu("sltu", 32'hFFFFFFFF, 32'd1, 4'b0011, 32'd0);
      check_alu("xor", 32'hF0F0F0F0, 32'h0FF00FF0, 4'b0100, 32'hFF00FF00);
      check_alu("or", 32'hF0F0F0F0, 32'h0FF00FF0, 4'b0110, 32'hFFF0FFF0);
      check_alu("and", 32'hF0F0F0F0, 32'h0FF00FF0, 4'b1111, 32'h00F000F0);
      check_alu("xor_b3", 32'hF0F0F0F0, 32'h0FF00FF0, 4'b1100, 32'hFF00FF00);

      // Random traffic on both the register file and the ALU.
      for (int i = 0; i < 400; i++) begin
         bus.we       = ($urandom_range(0, 3) != 0);
         bus.rd       = 5'($urandom_range(0, 31));
         bus.indata   = $urandom;
         bus.rs1      = ($urandom_range(0, 3) == 0) ? bus.rd : 5'($urandom_range(0, 31));
         bus.rs2      = ($urandom_range(0, 3) == 0) ? bus.rs1 : 5'($urandom_range(0, 31));
         bus.a        = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
         bus.b        = ($urandom_range(0, 7) == 0) ? bus.a : $urandom;
         bus.selectop = 4'($urandom_range(0, 15));
         #1;
         check_reads("rnd_rd");
         check("rnd_alu", bus.out, ref_alu(bus.a, bus.b, bus.selectop));
         check("rnd_flags",
               32'({bus.neq, bus.eq, bus.lt, bus.ge, bus.ltu, bus.geu, bus.zerof}),
               32'(ref_flags(bus.a, bus.b, bus.selectop)));
         tick();
      end
      bus.we = 1'b0;
      for (int i = 0; i < 32; i++) begin
         bus.rs1 = 5'(i);
         bus.rs2 = 5'(31 - i);
         #1;
         check_reads("final");
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
